alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Sequential front end for the team's combinational 5-bit ALU (4-bit select, two 5-bit operands, 5-bit result). It accepts operation commands over a valid/ready handshake, buffers them in a small FIFO, and presents each one to the ALU's select and operand inputs. After a programmable settle time it captures the ALU result and returns it, tagged, over a second valid/ready handshake. It replaces hand-timed stimulus on the ALU's inputs with a cycle-accurate initiator that the datapath controller can drive directly.

## Interface
- W, 5, operand/result width
- SW, 4, select width
- DEPTH, 4, command FIFO depth (power of two, >=2)
- SETTLE, 1, cycles the operands are held on the ALU before capture (>=1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO can accept; high iff FIFO count < DEPTH
- cmd_s  input  SW  ALU select for the command
- cmd_a  input  W  operand A
- cmd_b  input  W  operand B
- alu_s  output  SW  drives ALU select
- alu_a  output  W  drives ALU operand A
- alu_b  output  W  drives ALU operand B
- alu_y  input  W  ALU result (combinational from alu_s/a/b)
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  W  captured ALU result
- res_tag  output  8  sequence number of the command, starting at 0 after reset, +1 per completed result, wraps 255->0
- busy  output  1  high when FSM is not IDLE or FIFO is non-empty

## Operation
- Push when cmd_valid && cmd_ready. cmd_ready is computed from the count at the start of the cycle. A pop in the same cycle does not enable a push into a full FIFO.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if FIFO non-empty, pop the head into alu_s/alu_a/alu_b registers, load the settle counter with SETTLE-1, go to ISSUE. Otherwise stay.
- ISSUE: operands held constant. Decrement the counter; when it is 0, go to CAPTURE.
- CAPTURE: register alu_y into res_data, set res_valid, go to RESP.
- RESP: hold res_data, res_tag, and the alu_* values stable while res_valid && !res_ready. On res_ready, clear res_valid, increment res_tag, go to IDLE.
- Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, both take effect.
- Push into an empty FIFO in the same cycle the FSM is in IDLE: the entry is not visible until the next cycle. No bypass.
- Reset asserted at any time, including mid-RESP: the FIFO is emptied and any in-flight command and result are discarded.

## Timing
- Reset values: cmd_ready=1, alu_s=0, alu_a=0, alu_b=0, res_valid=0, res_data=0, res_tag=0, busy=0, state=IDLE, FIFO count=0.
- Single command accepted at edge k into an idle, empty block:
  - pop at edge k+1 (alu_* valid after k+1)
  - ISSUE occupies SETTLE cycles
  - capture at edge k+2+SETTLE
  - res_valid high after that edge
  - With SETTLE=1: res_valid is first seen high in cycle k+3.
- Throughput with res_ready tied high: one result every SETTLE+3 cycles (IDLE, ISSUE×SETTLE, CAPTURE, RESP).
- res_valid may drop only in the cycle after a handshake. res_data and res_tag do not change while res_valid=1.
- busy is combinational from the state and the FIFO count.

## Test plan
- Bench ALU stub: alu_y = (alu_a + alu_b) mod 32. SETTLE=1, DEPTH=4.
- Reset mid-operation: assert rst_n=0 while in RESP with a result pending. Required: res_valid=0, cmd_ready=1, busy=0, res_tag=0 immediately (asynchronous). After release, the first new command gets tag 0.
- Single op: push S=4'b1101, A=1, B=0 at edge k, res_ready=1. Required: alu_s=4'b1101 after k+1; res_valid in cycle k+3 with res_data=1, res_tag=0; busy=0 after the handshake.
- Back-pressure: hold res_ready=0, push 5 commands (A=2/B=1, 4/2, 8/4, 16/8, 1/1).
  - cmd_ready must drop once the FIFO holds 4 with one command in RESP.
  - res_data=3 must stay stable.
  - Release res_ready. Results must arrive in order: 3, 6, 12, 24, 2, with tags 0..4.
- Wrap-around: 258 commands A=1, B=1, res_ready=1. Required: res_tag sequence 0..255, 0, 1; every res_data=2.
- Simultaneous push/pop at count=2: push in the same cycle IDLE pops. Required: count stays 2 and order is preserved.
- Overflow sum: A=5'b10000, B=5'b10000. Required: res_data=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : FIFO-buffered command sequencer that drives a combinational ALU,
//            waits a programmable settle time and returns tagged results.
// Revision : 1.0
// ============================================================================
module alu_op_sequencer #(
    parameter int W      = 5,
    parameter int SW     = 4,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [SW-1:0] cmd_s,
    input  logic [W-1:0]  cmd_a,
    input  logic [W-1:0]  cmd_b,
    output logic [SW-1:0] alu_s,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic [7:0]    res_tag,
    output logic          busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int EW = SW + 2 * W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [CW-1:0] c_settle_load = CW'(SETTLE - 1);
    localparam logic [AW:0]   c_depth       = (AW + 1)'(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [CW-1:0] r_settle;

    logic [SW-1:0] r_alu_s;
    logic [W-1:0]  r_alu_a;
    logic [W-1:0]  r_alu_b;
    logic          r_res_valid;
    logic [W-1:0]  r_res_data;
    logic [7:0]    r_res_tag;

    logic w_push;
    logic w_pop;
    logic w_capture;
    logic w_done;

    // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
    assign cmd_ready = (r_count < c_depth);
    assign w_push    = cmd_valid && cmd_ready;

    assign alu_s     = r_alu_s;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_tag   = r_res_tag;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (r_count != '0) w_next_state = S_ISSUE;
            S_ISSUE:   if (r_settle == '0) w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_RESP;
            S_RESP:    if (res_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        w_pop     = (r_state == S_IDLE) && (r_count != '0);
        w_capture = (r_state == S_CAPTURE);
        w_done    = (r_state == S_RESP) && res_ready;
        busy      = (r_state != S_IDLE) || (r_count != '0);
    end

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_s, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_s     <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_settle    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
        end else begin
            if (w_pop) begin
                {r_alu_s, r_alu_a, r_alu_b} <= r_mem[r_rd_ptr];
                r_settle                    <= c_settle_load;
            end else if ((r_state == S_ISSUE) && (r_settle != '0)) begin
                r_settle <= r_settle - CW'(1);
            end
            if (w_capture) begin
                r_res_data  <= alu_y;
                r_res_valid <= 1'b1;
            end else if (w_done) begin
                r_res_valid <= 1'b0;
                r_res_tag   <= r_res_tag + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
